// File: rtl/alu_decoder_mext.sv
// alu_decoder_mext
//   ALU decoder with a registered valid/ready output stage. Decodes
//   Op/funct3/funct7/ALUOp into ALUControl for the RV32I ALU operations and,
//   when ENABLE_M=1, the RV32M operations. M-ops are held for MUL_CYCLES or
//   DIV_CYCLES before out_valid rises, and in_ready stays low meanwhile so that
//   the decode stage stalls on the multi-cycle unit.
//
// Ports
//   clk, rst    : rising-edge clock, synchronous active-high reset
//   in_valid    : decode request present
//   in_ready    : request accepted when in_valid & in_ready
//   Op          : instruction opcode (7)
//   funct3      : instruction funct3 (3)
//   funct7      : instruction funct7 (7)
//   ALUOp       : 00 add, 01 sub, 10 decode funct fields, 11 reserved
//   out_valid   : ALUControl/MDUSel/IllegalOp valid
//   out_ready   : consumer takes output when out_valid & out_ready
//   ALUControl  : decoded operation code, zero-extended to CTRL_W
//   MDUSel      : operation is an RV32M op
//   IllegalOp   : encoding not supported (ALUControl forced to ADD)
module alu_decoder_mext #(
    parameter int CTRL_W     = 5,
    parameter int ENABLE_M   = 1,
    parameter int MUL_CYCLES = 2,
    parameter int DIV_CYCLES = 33
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [6:0]        Op,
    input  logic [2:0]        funct3,
    input  logic [6:0]        funct7,
    input  logic [1:0]        ALUOp,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] ALUControl,
    output logic              MDUSel,
    output logic              IllegalOp
);

    localparam logic [4:0] C_ADD  = 5'b00000;
    localparam logic [4:0] C_SUB  = 5'b00001;
    localparam logic [4:0] C_AND  = 5'b00010;
    localparam logic [4:0] C_OR   = 5'b00011;
    localparam logic [4:0] C_XOR  = 5'b00100;
    localparam logic [4:0] C_SLT  = 5'b00101;
    localparam logic [4:0] C_SLL  = 5'b00110;
    localparam logic [4:0] C_SLTU = 5'b00111;
    localparam logic [4:0] C_SRL  = 5'b01000;
    localparam logic [4:0] C_SRA  = 5'b01001;

    localparam int MAX_LAT = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = (MAX_LAT > 2) ? $clog2(MAX_LAT) : 1;

    // WAIT is entered holding latency-2, so reaching zero means one more edge to FULL.
    localparam logic [CNT_W-1:0] MUL_INIT = CNT_W'((MUL_CYCLES > 1) ? MUL_CYCLES - 2 : 0);
    localparam logic [CNT_W-1:0] DIV_INIT = CNT_W'((DIV_CYCLES > 1) ? DIV_CYCLES - 2 : 0);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FULL = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [4:0]       ctrl_q;
    logic             mdu_q;
    logic             ill_q;

    logic [4:0] ctrl_d;
    logic       mdu_d;
    logic       ill_d;
    logic       is_m;
    logic       base_ill;
    logic       accept;
    logic       m_single;

    // Decode (combinational, registered on accept)
    assign is_m = (Op == 7'b0110011) && (funct7 == 7'b0000001);

    // Only evaluated for non-M encodings, so funct7=0000001 here is never a legal M-op.
    assign base_ill = (Op[5] && (funct7 != 7'h00) && (funct7 != 7'h20))
                   || ((funct7 == 7'h20) && (funct3 != 3'b000) && (funct3 != 3'b101))
                   || ((funct3 == 3'b001) && (funct7 != 7'h00));

    always_comb begin
        ctrl_d = C_ADD;
        mdu_d  = 1'b0;
        ill_d  = 1'b0;
        case (ALUOp)
            2'b00: ctrl_d = C_ADD;
            2'b01: ctrl_d = C_SUB;
            2'b10: begin
                if (is_m) begin
                    if (ENABLE_M != 0) begin
                        ctrl_d = {2'b10, funct3};
                        mdu_d  = 1'b1;
                    end else begin
                        ill_d  = 1'b1;
                    end
                end else if (base_ill) begin
                    ill_d = 1'b1;
                end else begin
                    case (funct3)
                        3'b000:  ctrl_d = (Op[5] && funct7[5]) ? C_SUB : C_ADD;
                        3'b001:  ctrl_d = C_SLL;
                        3'b010:  ctrl_d = C_SLT;
                        3'b011:  ctrl_d = C_SLTU;
                        3'b100:  ctrl_d = C_XOR;
                        3'b101:  ctrl_d = funct7[5] ? C_SRA : C_SRL;
                        3'b110:  ctrl_d = C_OR;
                        default: ctrl_d = C_AND;
                    endcase
                end
            end
            default: ill_d = 1'b1;
        endcase
    end

    assign in_ready = (state_q == S_IDLE) || ((state_q == S_FULL) && out_ready);
    assign accept   = in_valid && in_ready;

    // funct3[2] separates DIV/REM from MUL*.
    assign m_single = funct3[2] ? (DIV_CYCLES <= 1) : (MUL_CYCLES <= 1);

    // Output stage / occupancy FSM
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            ctrl_q  <= '0;
            mdu_q   <= 1'b0;
            ill_q   <= 1'b0;
        end else if (accept) begin
            ctrl_q <= ctrl_d;
            mdu_q  <= mdu_d;
            ill_q  <= ill_d;
            if (!mdu_d || m_single) begin
                state_q <= S_FULL;
            end else begin
                state_q <= S_WAIT;
                cnt_q   <= funct3[2] ? DIV_INIT : MUL_INIT;
            end
        end else begin
            case (state_q)
                S_FULL: begin
                    if (out_ready) begin
                        state_q <= S_IDLE;
                    end
                end
                S_WAIT: begin
                    if (cnt_q == '0) begin
                        state_q <= S_FULL;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign out_valid  = (state_q == S_FULL);
    assign ALUControl = CTRL_W'(ctrl_q);
    assign MDUSel     = mdu_q;
    assign IllegalOp  = ill_q;

endmodule

// File: tb/tb_alu_decoder_mext.sv
module tb_alu_decoder_mext;

    localparam int MUL_C = 2;
    localparam int DIV_C = 33;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [6:0] Op;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [1:0] ALUOp;
    logic       out_valid;
    logic       out_ready;
    logic [4:0] ALUControl;
    logic       MDUSel;
    logic       IllegalOp;

    // Second build without RV32M and with a wider control word.
    logic       n_in_valid;
    logic       n_in_ready;
    logic [6:0] n_Op;
    logic [2:0] n_funct3;
    logic [6:0] n_funct7;
    logic [1:0] n_ALUOp;
    logic       n_out_valid;
    logic       n_out_ready;
    logic [5:0] n_ALUControl;
    logic       n_MDUSel;
    logic       n_IllegalOp;

    int tests = 0;
    int fails = 0;

    alu_decoder_mext #(.CTRL_W(5), .ENABLE_M(1), .MUL_CYCLES(MUL_C), .DIV_CYCLES(DIV_C)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .Op(Op), .funct3(funct3), .funct7(funct7), .ALUOp(ALUOp),
        .out_valid(out_valid), .out_ready(out_ready),
        .ALUControl(ALUControl), .MDUSel(MDUSel), .IllegalOp(IllegalOp)
    );

    alu_decoder_mext #(.CTRL_W(6), .ENABLE_M(0), .MUL_CYCLES(MUL_C), .DIV_CYCLES(DIV_C)) u_nom (
        .clk(clk), .rst(rst), .in_valid(n_in_valid), .in_ready(n_in_ready),
        .Op(n_Op), .funct3(n_funct3), .funct7(n_funct7), .ALUOp(n_ALUOp),
        .out_valid(n_out_valid), .out_ready(n_out_ready),
        .ALUControl(n_ALUControl), .MDUSel(n_MDUSel), .IllegalOp(n_IllegalOp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference decode: returns {illegal, mdu, code[4:0]}.
    localparam logic [4:0] BASE_TAB [8] = '{5'd0, 5'd6, 5'd5, 5'd7, 5'd4, 5'd8, 5'd3, 5'd2};

    function automatic logic [6:0] ref_decode(input logic [1:0] aluop, input logic [6:0] op,
                                              input logic [2:0] f3, input logic [6:0] f7);
        logic [4:0] code;
        if (aluop == 2'b00) return 7'b00_00000;
        if (aluop == 2'b01) return 7'b00_00001;
        if (aluop == 2'b11) return 7'b10_00000;
        if (op == 7'h33 && f7 == 7'h01) return {2'b01, 2'b10, f3};
        if ((op[5] && f7 != 7'h00 && f7 != 7'h20) ||
            (f7 == 7'h20 && f3 != 3'd0 && f3 != 3'd5) ||
            (f3 == 3'd1 && f7 != 7'h00)) return 7'b10_00000;
        code = BASE_TAB[f3];
        if (f3 == 3'd0 && op[5] && f7[5]) code = 5'd1;
        if (f3 == 3'd5 && f7[5]) code = 5'd9;
        return {2'b00, code};
    endfunction

    // Transaction-level model: one slot, cycles remaining until visible.
    logic       chk_en = 1'b0;
    logic       m_have;
    int         m_rem;
    logic [4:0] m_ctrl;
    logic       m_mdu;
    logic       m_ill;
    logic       m_zero;

    always @(posedge clk) begin
        logic       acc;
        logic       fire;
        logic [6:0] d;
        if (rst) begin
            m_have <= 1'b0;
            m_rem  <= 0;
            m_ctrl <= '0;
            m_mdu  <= 1'b0;
            m_ill  <= 1'b0;
            m_zero <= 1'b1;
            chk_en <= 1'b1;
        end else if (chk_en) begin
            acc  = in_valid && (!m_have || (m_rem == 0 && out_ready));
            fire = m_have && m_rem == 0 && out_ready;
            d    = ref_decode(ALUOp, Op, funct3, funct7);
            if (acc) begin
                m_have <= 1'b1;
                m_rem  <= d[5] ? (funct3[2] ? DIV_C - 1 : MUL_C - 1) : 0;
                m_ill  <= d[6];
                m_mdu  <= d[5];
                m_ctrl <= d[4:0];
                m_zero <= 1'b0;
            end else if (fire) begin
                m_have <= 1'b0;
            end else if (m_have && m_rem > 0) begin
                m_rem <= m_rem - 1;
            end
        end
    end

    always @(negedge clk) begin
        logic exp_v;
        logic exp_r;
        if (chk_en) begin
            exp_v = m_have && (m_rem == 0);
            exp_r = !m_have || (m_rem == 0 && out_ready);
            chk("out_valid", 32'(out_valid), 32'(exp_v));
            chk("in_ready", 32'(in_ready), 32'(exp_r));
            if (exp_v || m_zero) begin
                chk("ALUControl", 32'(ALUControl), 32'(m_ctrl));
                chk("MDUSel", 32'(MDUSel), 32'(m_mdu));
                chk("IllegalOp", 32'(IllegalOp), 32'(m_ill));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] aluop, input logic [6:0] op,
                         input logic [2:0] f3, input logic [6:0] f7);
        ALUOp  = aluop;
        Op     = op;
        funct3 = f3;
        funct7 = f7;
    endtask

    initial begin
        int lowcnt;
        int steps;
        logic [6:0] sw_op;
        logic [6:0] sw_f7;
        int r;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        drive(2'b00, 7'h00, 3'd0, 7'h00);
        n_in_valid = 1'b0; n_out_ready = 1'b1;
        n_ALUOp = 2'b00; n_Op = 7'h00; n_funct3 = 3'd0; n_funct7 = 7'h00;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        chk("reset_ctrl", 32'(ALUControl), 32'd0);
        chk("reset_ill", 32'(IllegalOp), 32'd0);

        chk("model_sub", 32'(ref_decode(2'b10, 7'h33, 3'd0, 7'h20)), 32'h01);
        chk("model_sra", 32'(ref_decode(2'b10, 7'h33, 3'd5, 7'h20)), 32'h09);
        chk("model_div", 32'(ref_decode(2'b10, 7'h33, 3'd4, 7'h01)), 32'h34);

        // SUB, one-cycle latency
        drive(2'b10, 7'h33, 3'd0, 7'h20);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk("sub_valid", 32'(out_valid), 32'd1);
        chk("sub_ctrl", 32'(ALUControl), 32'h01);
        chk("sub_mdu", 32'(MDUSel), 32'd0);
        chk("sub_ill", 32'(IllegalOp), 32'd0);
        step();

        // ENABLE_M=0 build, MUL encoding
        n_ALUOp = 2'b10; n_Op = 7'h33; n_funct3 = 3'd0; n_funct7 = 7'h01;
        n_in_valid = 1'b1;
        step();
        n_in_valid = 1'b0;
        chk("nom_valid", 32'(n_out_valid), 32'd1);
        chk("nom_ill", 32'(n_IllegalOp), 32'd1);
        chk("nom_mdu", 32'(n_MDUSel), 32'd0);
        chk("nom_ctrl", 32'(n_ALUControl), 32'd0);
        step();

        // R/I sweep, back-to-back
        for (int oi = 0; oi < 2; oi++) begin
            for (int fi = 0; fi < 2; fi++) begin
                for (int f3 = 0; f3 < 8; f3++) begin
                    sw_op = (oi == 0) ? 7'h33 : 7'h13;
                    sw_f7 = (fi == 0) ? 7'h00 : 7'h20;
                    drive(2'b10, sw_op, 3'(f3), sw_f7);
                    in_valid = 1'b1;
                    step();
                    if (oi == 0 && fi == 1 && f3 == 5)
                        chk("sweep_sra", 32'(ALUControl), 32'h09);
                    if (fi == 1 && f3 == 1) begin
                        chk("sweep_ill", 32'(IllegalOp), 32'd1);
                        chk("sweep_ill_ctrl", 32'(ALUControl), 32'd0);
                    end
                end
            end
        end
        in_valid = 1'b0;
        step();

        // DIV occupancy
        drive(2'b10, 7'h33, 3'd4, 7'h01);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        lowcnt = 0;
        steps = 0;
        while (!out_valid && steps < 50) begin
            if (!in_ready) lowcnt++;
            step();
            steps++;
        end
        chk("div_in_ready_low", 32'(lowcnt), 32'd32);
        chk("div_latency", 32'(steps + 1), 32'd33);
        chk("div_ctrl", 32'(ALUControl), 32'h14);
        chk("div_mdu", 32'(MDUSel), 32'd1);
        step();

        // MUL with held output
        drive(2'b10, 7'h33, 3'd0, 7'h01);
        out_ready = 1'b0;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk("mul_wait_valid", 32'(out_valid), 32'd0);
        step();
        for (int k = 0; k < 5; k++) begin
            chk("mul_hold_valid", 32'(out_valid), 32'd1);
            chk("mul_hold_ctrl", 32'(ALUControl), 32'h10);
            chk("mul_hold_mdu", 32'(MDUSel), 32'd1);
            chk("mul_hold_in_ready", 32'(in_ready), 32'd0);
            step();
        end
        drive(2'b00, 7'h00, 3'd0, 7'h00);
        in_valid = 1'b1;
        out_ready = 1'b1;
        #1;
        chk("b2b_in_ready", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        chk("b2b_valid", 32'(out_valid), 32'd1);
        chk("b2b_ctrl", 32'(ALUControl), 32'd0);
        chk("b2b_mdu", 32'(MDUSel), 32'd0);
        step();

        // Reset during a DIV
        drive(2'b10, 7'h33, 3'd4, 7'h01);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (9) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_wait_valid", 32'(out_valid), 32'd0);
        chk("rst_wait_ctrl", 32'(ALUControl), 32'd0);
        chk("rst_wait_mdu", 32'(MDUSel), 32'd0);
        chk("rst_wait_ill", 32'(IllegalOp), 32'd0);
        chk("rst_wait_in_ready", 32'(in_ready), 32'd1);
        drive(2'b10, 7'h33, 3'd0, 7'h00);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk("post_rst_valid", 32'(out_valid), 32'd1);
        chk("post_rst_ctrl", 32'(ALUControl), 32'd0);
        chk("post_rst_ill", 32'(IllegalOp), 32'd0);

        // Randomized traffic
        for (int c = 0; c < 4000; c++) begin
            rst       = ($urandom_range(0, 399) == 0);
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 7);
            r = $urandom_range(0, 9);
            ALUOp = (r < 7) ? 2'b10 : (r == 7) ? 2'b00 : (r == 8) ? 2'b01 : 2'b11;
            r = $urandom_range(0, 2);
            Op = (r == 0) ? 7'h33 : (r == 1) ? 7'h13 : 7'($urandom);
            r = $urandom_range(0, 4);
            funct7 = (r < 2) ? 7'h00 : (r == 2) ? 7'h20 : (r == 3) ? 7'h01 : 7'($urandom);
            funct3 = 3'($urandom);
            step();
        end
        rst = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (40) step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
